// File: rtl/rtl_settings_pkg.sv
// Shared types and constants for the memory-checker test sequencer.
package rtl_settings_pkg;

  localparam int DRAIN_IDLE_CYCLES = 2;

  typedef enum logic [1:0] {
    WR_ONLY = 2'd0,
    RD_ONLY = 2'd1,
    WR_RD   = 2'd2
  } test_mode_t;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_ERR     = 2'd1,
    RES_TIMEOUT = 2'd2
  } test_result_t;

  // Encoding 3 has no meaning of its own and runs as write-then-read.
  function automatic test_mode_t decode_mode(input logic [1:0] mode);
    case (mode)
      2'd0:    return WR_ONLY;
      2'd1:    return RD_ONLY;
      default: return WR_RD;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the test sequencer: counts while enabled and flags expiry at the limit.
module seq_watchdog #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the watchdog.
  assign expired_o = (limit_i != '0) && (cnt_q == limit_i);

endmodule

// File: rtl/test_sequencer.sv
// Test controller for the memory checker: clear, write phase and/or read phase, drain, report.
// Build option TEST_SEQ_STOP_ON_ERROR_EN: the first compare error in the read phase ends the requests.
module test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int TRANS_CNT_W = 16,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             test_mode_i,
  input  logic [TRANS_CNT_W-1:0] trans_amount_i,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  output logic                   gen_valid_o,
  output logic                   gen_op_o,
  input  logic                   gen_ready_i,
  output logic                   meas_start_o,
  input  logic                   meas_busy_i,
  input  logic                   cmp_error_i,
  output logic                   test_busy_o,
  output logic                   test_done_o,
  output logic [1:0]             test_result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WR_ISSUE,
    S_WR_DRAIN,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_FINISH
  } state_t;

  localparam int LOW_W = $clog2(DRAIN_IDLE_CYCLES + 1);

  state_t                 state_q, state_d;
  test_mode_t             mode_q, mode_d;
  logic [TRANS_CNT_W-1:0] amount_q, amount_d;
  logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;
  logic [TRANS_CNT_W-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   tmo_q, tmo_d;
  logic                   done_q, done_d;
  test_result_t           result_q, result_d;
  logic                   busy_prev_q, busy_prev_d;
  logic [LOW_W-1:0]       low_cnt_q, low_cnt_d;
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
  logic                   stop_q, stop_d;
`endif

  logic in_issue;
  logic in_drain;
  logic handshake;
  logic drain_done;
  logic busy_fall;
  logic wd_clear;
  logic wd_expired;

  assign in_issue   = (state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE);
  assign in_drain   = (state_q == S_WR_DRAIN) || (state_q == S_RD_DRAIN);
  assign handshake  = gen_valid_o && gen_ready_i;
  assign busy_fall  = busy_prev_q && !meas_busy_i;
  assign drain_done = in_drain && !meas_busy_i && (low_cnt_q >= LOW_W'(DRAIN_IDLE_CYCLES - 1));
  assign wd_clear   = (state_d != state_q) || handshake || busy_fall;

  seq_watchdog #(
    .W (TIMEOUT_W)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear),
    .inc_i     (in_issue || in_drain),
    .limit_i   (timeout_q),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    amount_d    = amount_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    done_d      = done_q;
    result_d    = result_q;
    busy_prev_d = meas_busy_i;
    low_cnt_d   = '0;
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
    stop_d      = stop_q;
`endif

    if (in_drain && !meas_busy_i && (low_cnt_q < LOW_W'(DRAIN_IDLE_CYCLES))) begin
      low_cnt_d = low_cnt_q + LOW_W'(1);
    end
    if ((state_q != S_IDLE) && cmp_error_i) begin
      err_d = 1'b1;
    end
    if ((in_issue || in_drain) && wd_expired) begin
      tmo_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = decode_mode(test_mode_i);
          amount_d  = trans_amount_i;
          timeout_d = timeout_i;
          done_d    = 1'b0;
          result_d  = RES_OK;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        err_d = 1'b0;
        tmo_d = 1'b0;
        cnt_d = amount_q;
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
        stop_d = 1'b0;
`endif
        if (mode_q == RD_ONLY) begin
          state_d = (amount_q == '0) ? S_RD_DRAIN : S_RD_ISSUE;
        end else begin
          state_d = (amount_q == '0) ? S_WR_DRAIN : S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (wd_expired) begin
          state_d = S_FINISH;
        end else if (handshake) begin
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - TRANS_CNT_W'(1);
          if (cnt_q <= TRANS_CNT_W'(1)) begin
            state_d = S_WR_DRAIN;
          end
        end
      end
      S_RD_ISSUE: begin
        if (wd_expired) begin
          state_d = S_FINISH;
        end else begin
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
          // A request already on the bus must still complete before stopping.
          if (cmp_error_i) begin
            stop_d = 1'b1;
          end
          if (handshake) begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - TRANS_CNT_W'(1);
            if ((cnt_q <= TRANS_CNT_W'(1)) || stop_q || cmp_error_i) begin
              state_d = S_RD_DRAIN;
            end
          end
`else
          if (handshake) begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - TRANS_CNT_W'(1);
            if (cnt_q <= TRANS_CNT_W'(1)) begin
              state_d = S_RD_DRAIN;
            end
          end
`endif
        end
      end
      S_WR_DRAIN: begin
        if (wd_expired) begin
          state_d = S_FINISH;
        end else if (drain_done) begin
          if (mode_q == WR_ONLY) begin
            state_d = S_FINISH;
          end else begin
            cnt_d   = amount_q;
            state_d = (amount_q == '0) ? S_RD_DRAIN : S_RD_ISSUE;
          end
        end
      end
      S_RD_DRAIN: begin
        if (wd_expired || drain_done) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        if (tmo_q) begin
          result_d = RES_TIMEOUT;
        end else if (err_q || cmp_error_i) begin
          result_d = RES_ERR;
        end else begin
          result_d = RES_OK;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= WR_ONLY;
      amount_q    <= '0;
      timeout_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= RES_OK;
      busy_prev_q <= 1'b0;
      low_cnt_q   <= '0;
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
      stop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      amount_q    <= amount_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      result_q    <= result_d;
      busy_prev_q <= busy_prev_d;
      low_cnt_q   <= low_cnt_d;
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
      stop_q      <= stop_d;
`endif
    end
  end

  // The watchdog withdraws a pending request so the run can finish without a handshake.
  assign gen_valid_o   = in_issue && !wd_expired;
  assign gen_op_o      = gen_valid_o && (state_q == S_RD_ISSUE);
  assign meas_start_o  = (state_q == S_CLEAR);
  assign test_busy_o   = (state_q != S_IDLE);
  assign test_done_o   = done_q;
  assign test_result_o = result_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: directed runs push expected events, a monitor pops and compares.
module tb_test_sequencer;

  localparam int CW = 16;
  localparam int TW = 16;

  localparam int EV_MEAS  = 1;
  localparam int EV_WR    = 2;
  localparam int EV_RD    = 3;
  localparam int EV_VDROP = 4;
  localparam int EV_DONE  = 5;

  logic          clk_i          = 1'b0;
  logic          rst_i          = 1'b1;
  logic          start_i        = 1'b0;
  logic [1:0]    test_mode_i    = 2'd0;
  logic [CW-1:0] trans_amount_i = '0;
  logic [TW-1:0] timeout_i      = '0;
  logic          gen_ready_i    = 1'b0;
  logic          meas_busy_i    = 1'b0;
  logic          cmp_error_i    = 1'b0;
  logic          gen_valid_o;
  logic          gen_op_o;
  logic          meas_start_o;
  logic          test_busy_o;
  logic          test_done_o;
  logic [1:0]    test_result_o;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  int busy_tail   = 5;
  int busy_hold   = 0;
  int err_on_read = 0;
  int err_at_rel  = -1;
  int cycle_cnt   = 0;
  int meas_cycle  = 0;
  int vrun        = 0;
  int rd_seen     = 0;
  logic prev_valid = 1'b0;
  logic prev_done  = 1'b0;

  test_sequencer #(
    .TRANS_CNT_W (CW),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .test_mode_i    (test_mode_i),
    .trans_amount_i (trans_amount_i),
    .timeout_i      (timeout_i),
    .gen_valid_o    (gen_valid_o),
    .gen_op_o       (gen_op_o),
    .gen_ready_i    (gen_ready_i),
    .meas_start_o   (meas_start_o),
    .meas_busy_i    (meas_busy_i),
    .cmp_error_i    (cmp_error_i),
    .test_busy_o    (test_busy_o),
    .test_done_o    (test_done_o),
    .test_result_o  (test_result_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int ev(input int kind, input int a, input int b);
    return kind * 100000 + a * 1000 + b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic popCompare(input string name, input int actual);
    if (exp_q.size() == 0) begin
      checkOutput({name, "_unexpected"}, actual, -1);
    end else begin
      checkOutput(name, actual, exp_q.pop_front());
    end
  endtask

  // Monitor plus measure-block and comparator models, all evaluated mid-cycle.
  always @(negedge clk_i) begin
    cycle_cnt++;
    if (meas_start_o) begin
      meas_cycle = cycle_cnt;
      rd_seen    = 0;
      popCompare("meas_start", ev(EV_MEAS, 0, 0));
    end
    if (gen_valid_o && gen_ready_i) begin
      popCompare("request", ev(gen_op_o ? EV_RD : EV_WR, 0, 0));
      vrun = 0;
    end else if (gen_valid_o) begin
      vrun++;
    end else if (prev_valid && vrun > 0) begin
      popCompare("valid_drop", ev(EV_VDROP, vrun, 0));
      vrun = 0;
    end
    if (test_done_o && !prev_done) begin
      popCompare("done", ev(EV_DONE, int'(test_result_o), cycle_cnt - meas_cycle));
    end
    prev_valid = gen_valid_o;
    prev_done  = test_done_o;

    if (gen_valid_o && gen_ready_i) busy_hold = busy_tail;
    else if (busy_hold > 0) busy_hold--;
    meas_busy_i = (busy_hold > 0);

    cmp_error_i = 1'b0;
    if (gen_valid_o && gen_ready_i && gen_op_o) begin
      rd_seen++;
      if (rd_seen == err_on_read) cmp_error_i = 1'b1;
    end
    if (err_at_rel >= 0 && (cycle_cnt - meas_cycle) == err_at_rel) cmp_error_i = 1'b1;
  end

  task automatic applyStimulus(input int mode, input int amount, input int tmo, input logic ready,
                               input int tail, input int err_rd, input int err_rel);
    @(negedge clk_i);
    test_mode_i    = 2'(mode);
    trans_amount_i = CW'(amount);
    timeout_i      = TW'(tmo);
    gen_ready_i    = ready;
    busy_tail      = tail;
    err_on_read    = err_rd;
    err_at_rel     = err_rel;
    start_i        = 1'b1;
    @(negedge clk_i);
    start_i        = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!test_done_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("done_within_budget", int'(test_done_o), 1);
    repeat (2) @(negedge clk_i);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gen_valid"}, int'(gen_valid_o), 0);
    checkOutput({tag, "_gen_op"}, int'(gen_op_o), 0);
    checkOutput({tag, "_meas_start"}, int'(meas_start_o), 0);
    checkOutput({tag, "_busy"}, int'(test_busy_o), 0);
    checkOutput({tag, "_done"}, int'(test_done_o), 0);
    checkOutput({tag, "_result"}, int'(test_result_o), 0);
  endtask

  initial begin
    int n;
    int rd;
    int n_rd;
    int lat4;

    repeat (3) @(negedge clk_i);
    checkAllZero("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Test 1: write-then-read, 4 each, clean run.
    exp_q.push_back(ev(EV_MEAS, 0, 0));
    repeat (4) exp_q.push_back(ev(EV_WR, 0, 0));
    repeat (4) exp_q.push_back(ev(EV_RD, 0, 0));
    exp_q.push_back(ev(EV_DONE, 0, 22));
    applyStimulus(2, 4, 0, 1'b1, 5, 0, -1);
    waitDone(200);

    // Test 2: read-only with zero transactions skips straight to drain.
    exp_q.push_back(ev(EV_MEAS, 0, 0));
    exp_q.push_back(ev(EV_DONE, 0, 4));
    applyStimulus(1, 0, 0, 1'b1, 5, 0, -1);
    waitDone(100);

    // Test 3: generator never ready, watchdog of 10 cycles.
    exp_q.push_back(ev(EV_MEAS, 0, 0));
    exp_q.push_back(ev(EV_VDROP, 10, 0));
    exp_q.push_back(ev(EV_DONE, 2, 13));
    applyStimulus(0, 3, 10, 1'b0, 5, 0, -1);
    waitDone(100);

    // Test 4: compare error on the third read.
`ifdef TEST_SEQ_STOP_ON_ERROR_EN
    n_rd = 3;
    lat4 = 25;
`else
    n_rd = 8;
    lat4 = 30;
`endif
    exp_q.push_back(ev(EV_MEAS, 0, 0));
    repeat (8) exp_q.push_back(ev(EV_WR, 0, 0));
    repeat (n_rd) exp_q.push_back(ev(EV_RD, 0, 0));
    exp_q.push_back(ev(EV_DONE, 1, lat4));
    applyStimulus(2, 8, 0, 1'b1, 5, 3, -1);
    waitDone(200);

    // Test 5: second start mid-run is ignored; reset during the read phase.
    exp_q.push_back(ev(EV_MEAS, 0, 0));
    repeat (4) exp_q.push_back(ev(EV_WR, 0, 0));
    repeat (2) exp_q.push_back(ev(EV_RD, 0, 0));
    applyStimulus(2, 4, 0, 1'b1, 5, 0, -1);
    repeat (6) @(negedge clk_i);
    test_mode_i = 2'd1;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
    n  = 0;
    rd = 0;
    while (rd < 2 && n < 100) begin
      @(negedge clk_i);
      n++;
      if (gen_valid_o && gen_ready_i && gen_op_o) rd++;
    end
    checkOutput("reads_before_reset", rd, 2);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkAllZero("midrun_reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("queue_drained", exp_q.size(), 0);
    repeat (10) @(negedge clk_i);

    // Test 6: error first, then timeout; timeout wins.
    exp_q.push_back(ev(EV_MEAS, 0, 0));
    exp_q.push_back(ev(EV_VDROP, 6, 0));
    exp_q.push_back(ev(EV_DONE, 2, 9));
    applyStimulus(0, 2, 6, 1'b0, 5, 0, 1);
    waitDone(100);
    err_at_rel = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
